// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle RV32I control FSM with memory handshake and retire counter
//
// Sequences IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH and drives the datapath
// selects from the instruction register. Optional feature macro: ILLEGAL_TRAP_EN (unknown
// opcodes park the FSM in TRAP instead of retiring as a NOP).
//
// Ports:
//   clk, reset (async, active-low)
//   instruction  : instruction register contents, valid from DECODE onward
//   mem_ready    : memory completes the current request this cycle
//   branch_taken : branch comparator result, used in EXEC
//   mem_req/mem_we, ir_write, pc_write/pc_sel : strobes
//   imm_sel, alu_src_a, alu_src_b, wb_sel, reg_write : datapath selects
//   instret      : retired-instruction count (wraps)
//   bus_timeout  : sticky, memory did not answer within WAIT_LIMIT cycles
//   trap         : sticky illegal-opcode flag
module multicycle_control_unit #(
    parameter int CNT_W      = 32,
    parameter int WAIT_LIMIT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instruction,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_sel,
    output logic [2:0]       imm_sel,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic [CNT_W-1:0] instret,
    output logic             bus_timeout,
    output logic             trap
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int WW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

    state_t        state, next;
    logic [WW-1:0] wait_cnt;
    logic          timeout_set;
    logic          limit_hit;
    logic          sel_active;
    logic          legal;
    logic [6:0]    opcode;
    logic          is_load, is_store, is_branch, is_jump;
    logic          unused_bits;

    assign opcode      = instruction[6:0];
    assign unused_bits = ^instruction[31:7];
    assign is_load     = (opcode == OP_LOAD);
    assign is_store    = (opcode == OP_STORE);
    assign is_branch   = (opcode == OP_BRANCH);
    assign is_jump     = (opcode == OP_JAL) || (opcode == OP_JALR);
    assign legal       = is_load || is_store || is_branch || is_jump ||
                         (opcode == OP_IMM) || (opcode == OP_OP) ||
                         (opcode == OP_LUI) || (opcode == OP_AUIPC);

    // The cycle that would be the WAIT_LIMIT-th unanswered one times out; a mem_ready
    // arriving in that same cycle completes the request instead.
    assign limit_hit  = (WAIT_LIMIT != 0) && !mem_ready && (wait_cnt == WW'(WAIT_LIMIT - 1));
    assign sel_active = (state == S_DECODE) || (state == S_EXEC) || (state == S_MEM) || (state == S_WB);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            instret     <= '0;
            bus_timeout <= 1'b0;
        end else begin
            state <= next;
            // Leaving FETCH/MEM only happens via mem_ready or timeout, so clearing on
            // mem_ready and outside those states restarts the count on every entry.
            if (((state == S_FETCH) || (state == S_MEM)) && !mem_ready)
                wait_cnt <= wait_cnt + WW'(1);
            else
                wait_cnt <= '0;
            if (pc_write)
                instret <= instret + CNT_W'(1);
            if (timeout_set)
                bus_timeout <= 1'b1;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic trap_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            trap_q <= 1'b0;
        else if ((state == S_DECODE) && !legal)
            trap_q <= 1'b1;
    end
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        next        = state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_sel      = 1'b0;
        reg_write   = 1'b0;
        timeout_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (!bus_timeout)
                    next = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    next     = S_DECODE;
                end else if (limit_hit) begin
                    timeout_set = 1'b1;
                    next        = S_IDLE;
                end
            end
            S_DECODE: begin
                next = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
                if (!legal)
                    next = S_TRAP;
`endif
            end
            S_EXEC: begin
                if (is_load || is_store) begin
                    next = S_MEM;
                end else if (is_branch) begin
                    pc_write = 1'b1;
                    pc_sel   = branch_taken;
                    next     = S_FETCH;
                end else begin
                    next = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_write = 1'b1;
                        next     = S_FETCH;
                    end else begin
                        next = S_WB;
                    end
                end else if (limit_hit) begin
                    timeout_set = 1'b1;
                    next        = S_IDLE;
                end
            end
            S_WB: begin
                reg_write = legal;   // unknown opcodes retire as NOP without a register write
                pc_write  = 1'b1;
                pc_sel    = is_jump;
                next      = S_FETCH;
            end
            S_TRAP: next = S_TRAP;
            default: next = S_IDLE;
        endcase
    end

    always_comb begin
        imm_sel   = 3'd0;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        wb_sel    = 2'd0;
        if (sel_active) begin
            case (opcode)
                OP_LOAD:   begin alu_src_b = 1'b1; wb_sel = 2'd1; end
                OP_STORE:  begin imm_sel = 3'd1; alu_src_b = 1'b1; end
                OP_IMM:    alu_src_b = 1'b1;
                OP_BRANCH: begin imm_sel = 3'd2; alu_src_a = 1'b1; end
                OP_JAL:    begin imm_sel = 3'd4; alu_src_a = 1'b1; alu_src_b = 1'b1; wb_sel = 2'd2; end
                OP_JALR:   begin alu_src_b = 1'b1; wb_sel = 2'd2; end
                OP_LUI:    begin imm_sel = 3'd3; alu_src_b = 1'b1; end
                OP_AUIPC:  begin imm_sel = 3'd3; alu_src_a = 1'b1; alu_src_b = 1'b1; end
                default:   ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - randomized self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

    localparam int CNT_W      = 4;
    localparam int WAIT_LIMIT = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      instruction;
    logic             mem_ready, branch_taken;
    logic             mem_req, mem_we, ir_write, pc_write, pc_sel;
    logic [2:0]       imm_sel;
    logic             alu_src_a, alu_src_b, reg_write;
    logic [1:0]       wb_sel;
    logic [CNT_W-1:0] instret;
    logic             bus_timeout, trap;

    multicycle_control_unit #(.CNT_W(CNT_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
        .pc_write(pc_write), .pc_sel(pc_sel), .imm_sel(imm_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .reg_write(reg_write), .wb_sel(wb_sel), .instret(instret),
        .bus_timeout(bus_timeout), .trap(trap)
    );

    always #5 clk = ~clk;

    // Opcode rule table: selects and instruction class. kind: 0 via WB, 1 load, 2 store, 3 branch.
    typedef struct packed {
        logic [6:0] op;
        logic [2:0] imm;
        logic       a;
        logic       b;
        logic [1:0] wb;
        logic [1:0] kind;
        logic       jmp;
        logic       legal;
    } opinfo_t;

    opinfo_t tbl [9];
    opinfo_t no_sel;

    logic             e_mem_req, e_mem_we, e_ir_write, e_pc_write, e_pc_sel;
    logic [2:0]       e_imm;
    logic             e_a, e_b, e_reg_write;
    logic [1:0]       e_wb;
    logic [CNT_W-1:0] e_instret;
    logic             e_timeout, e_trap;
    logic             chk_en = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_no = 0;
    int ir_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc_no++;
    always @(negedge clk) if (ir_write === 1'b1) ir_q.push_back(cyc_no);

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req", mem_req, e_mem_req);
            chk("mem_we", mem_we, e_mem_we);
            chk("ir_write", ir_write, e_ir_write);
            chk("pc_write", pc_write, e_pc_write);
            chk("pc_sel", pc_sel, e_pc_sel);
            chk("imm_sel", imm_sel, e_imm);
            chk("alu_src_a", alu_src_a, e_a);
            chk("alu_src_b", alu_src_b, e_b);
            chk("reg_write", reg_write, e_reg_write);
            chk("wb_sel", wb_sel, e_wb);
            chk("instret", instret, e_instret);
            chk("bus_timeout", bus_timeout, e_timeout);
            chk("trap", trap, e_trap);
        end
    end

    function automatic opinfo_t lookup(input logic [6:0] op);
        opinfo_t r = '0;
        for (int i = 0; i < 9; i++)
            if (tbl[i].op == op) r = tbl[i];
        return r;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(1));
    endfunction

    task automatic set_exp(input logic rdy, input logic bt, input logic mreq, input logic mwe,
                           input logic irw, input logic pcw, input logic pcs, input logic rw,
                           input logic sel, input opinfo_t inf);
        mem_ready    = rdy;
        branch_taken = bt;
        e_mem_req    = mreq;
        e_mem_we     = mwe;
        e_ir_write   = irw;
        e_pc_write   = pcw;
        e_pc_sel     = pcs;
        e_reg_write  = rw;
        e_imm        = sel ? inf.imm : 3'd0;
        e_a          = sel ? inf.a   : 1'b0;
        e_b          = sel ? inf.b   : 1'b0;
        e_wb         = sel ? inf.wb  : 2'd0;
    endtask

    task automatic cyc(input logic rdy, input logic bt, input logic mreq, input logic mwe,
                       input logic irw, input logic pcw, input logic pcs, input logic rw,
                       input logic sel, input opinfo_t inf);
        set_exp(rdy, bt, mreq, mwe, irw, pcw, pcs, rw, sel, inf);
        @(posedge clk);
        #1;
        if (pcw) e_instret = e_instret + 1'b1;
    endtask

    task automatic idle_run(input int n);
        for (int i = 0; i < n; i++)
            cyc(rb(), rb(), 0, 0, 0, 0, 0, 0, 0, no_sel);
    endtask

    // One instruction from FETCH to its retirement (or timeout / trap), waits >= WAIT_LIMIT time out.
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic tk);
        opinfo_t inf;
        inf = lookup(ins[6:0]);
        instruction = $urandom;
        for (int w = 0; w <= fw; w++) begin
            if (w == WAIT_LIMIT) begin
                e_timeout = 1'b1;
                idle_run(3);
                return;
            end
            cyc(w == fw, rb(), 1, 0, w == fw, 0, 0, 0, 0, inf);
        end
        instruction = ins;
        cyc(rb(), rb(), 0, 0, 0, 0, 0, 0, 1, inf);
`ifdef ILLEGAL_TRAP_EN
        if (!inf.legal) begin
            e_trap = 1'b1;
            idle_run(3);
            return;
        end
`endif
        if (inf.kind == 2'd3) begin
            cyc(rb(), tk, 0, 0, 0, 1, tk, 0, 1, inf);
            return;
        end
        cyc(rb(), rb(), 0, 0, 0, 0, 0, 0, 1, inf);
        if (inf.kind == 2'd1 || inf.kind == 2'd2) begin
            for (int w = 0; w <= mw; w++) begin
                if (w == WAIT_LIMIT) begin
                    e_timeout = 1'b1;
                    idle_run(3);
                    return;
                end
                cyc(w == mw, rb(), 1, inf.kind == 2'd2, 0, (inf.kind == 2'd2) && (w == mw), 0, 0, 1, inf);
            end
            if (inf.kind == 2'd2) return;
        end
        cyc(rb(), rb(), 0, 0, 0, 1, inf.jmp, inf.legal, 1, inf);
    endtask

    task automatic zero_model();
        set_exp(mem_ready, branch_taken, 0, 0, 0, 0, 0, 0, 0, no_sel);
        e_instret = '0;
        e_timeout = 1'b0;
        e_trap    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        zero_model();
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_run(1);
    endtask

    initial begin
        int base;
        logic [31:0] r;
        int k;
        tbl[0] = '{7'h03, 3'd0, 1'b0, 1'b1, 2'd1, 2'd1, 1'b0, 1'b1};
        tbl[1] = '{7'h23, 3'd1, 1'b0, 1'b1, 2'd0, 2'd2, 1'b0, 1'b1};
        tbl[2] = '{7'h13, 3'd0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1};
        tbl[3] = '{7'h33, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1};
        tbl[4] = '{7'h63, 3'd2, 1'b1, 1'b0, 2'd0, 2'd3, 1'b0, 1'b1};
        tbl[5] = '{7'h6F, 3'd4, 1'b1, 1'b1, 2'd2, 2'd0, 1'b1, 1'b1};
        tbl[6] = '{7'h67, 3'd0, 1'b0, 1'b1, 2'd2, 2'd0, 1'b1, 1'b1};
        tbl[7] = '{7'h37, 3'd3, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1};
        tbl[8] = '{7'h17, 3'd3, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1};
        no_sel = '0;

        reset = 1'b0;
        mem_ready = 1'b0;
        branch_taken = 1'b0;
        instruction = '0;
        zero_model();
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("reset_instret", instret, 0);
        chk("reset_mem_req", mem_req, 0);
        reset = 1'b1;
        idle_run(1);

        // Directed programs with literal latency / count pins
        base = ir_q.size();
        run_instr(32'h00500093, 0, 0, 1'b0);
        chk("addi_instret", instret, 1);
        run_instr(32'h00000463, 0, 0, 1'b1);
        run_instr(32'h00000463, 0, 0, 1'b0);
        run_instr(32'h00112223, 0, 3, 1'b0);
        run_instr(32'h00500093, 0, 0, 1'b0);
        chk("dir_instret", instret, 5);
        chk("gap_addi", ir_q[base+1] - ir_q[base], 4);
        chk("gap_beq_taken", ir_q[base+2] - ir_q[base+1], 3);
        chk("gap_beq_not", ir_q[base+3] - ir_q[base+2], 3);
        chk("gap_sw_wait3", ir_q[base+4] - ir_q[base+3], 7);

        // Asynchronous reset in the middle of a FETCH wait
        set_exp(1'b0, 1'b0, 1, 0, 0, 0, 0, 0, 0, no_sel);
        #6;
        reset = 1'b0;
        #1;
        chk("async_mem_req", mem_req, 0);
        chk("async_instret", instret, 0);
        zero_model();
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_run(1);
        run_instr(32'h00500093, 0, 0, 1'b0);
        chk("post_reset_instret", instret, 1);

        // Timeouts in FETCH and in MEM
        do_reset();
        run_instr(32'h00500093, WAIT_LIMIT, 0, 1'b0);
        chk("fetch_timeout", bus_timeout, 1);
        chk("fetch_timeout_req", mem_req, 0);
        do_reset();
        run_instr(32'h00002083, 0, WAIT_LIMIT, 1'b0);
        chk("mem_timeout", bus_timeout, 1);
        chk("mem_timeout_instret", instret, 0);

        // Unknown opcode
        do_reset();
        run_instr(32'h0000007F, 0, 0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        chk("illegal_trap", trap, 1);
        chk("illegal_instret", instret, 0);
`else
        chk("illegal_trap", trap, 0);
        chk("illegal_instret", instret, 1);
`endif
        do_reset();

        // Randomized programs; CNT_W=4 makes instret wrap along the way
        for (int i = 0; i < 80; i++) begin
            r = $urandom;
`ifdef ILLEGAL_TRAP_EN
            k = $urandom_range(8);
`else
            k = $urandom_range(11);
`endif
            case (k)
                9:       r[6:0] = 7'h0F;
                10:      r[6:0] = 7'h73;
                11:      r[6:0] = 7'h00;
                default: r[6:0] = tbl[k].op;
            endcase
            run_instr(r, $urandom_range(3), $urandom_range(3), rb());
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
